ext_stage: RTL and testbench
============================

Name: ext_stage

Overview:
- Parametrised, registered immediate-extension stage for the MIPS datapath.
- Widens an IN_W-bit immediate to OUT_W bits under one of six modes, including a branch-offset mode.
- Delivers the result through a valid/ready handshake with a 2-entry skid buffer, so the decode/execute boundary can stall without a combinational ready path.
- Supports synchronous flush for exception and branch squash.

Parameters:
IN_W, 16, immediate width; 1 <= IN_W < OUT_W
OUT_W, 32, result width
TAG_W, 5, width of a sideband tag carried alongside each result, e.g. destination register

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous squash of all buffered entries
in_valid  in  1  input entry present
in_ready  out  1  stage can accept an entry this cycle
imm  in  IN_W  raw immediate
mode  in  3  extension mode, encodings in ext_pkg
tag  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts the result this cycle
result  out  OUT_W  extended value
out_tag  out  TAG_W  tag of the result
err  out  1  result came from an illegal mode; qualified by out_valid

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Reset values: out_valid=0, result=0, out_tag=0, err=0, both buffer valids=0. in_ready=1 from the first cycle after reset.
- Modes (computed combinationally on input, then registered):
  - 0 ZERO: zero-extend.
  - 1 SIGN: sign-extend from imm[IN_W-1].
  - 2 HIGH: {imm, (OUT_W-IN_W) zeros}.
  - 3 ONES: {(OUT_W-IN_W) ones, imm}.
  - 4 SHL2: sign-extend, then shift left 2, truncated to OUT_W.
  - 5 SHL2Z: zero-extend, then shift left 2, truncated.
  - 6, 7 illegal: result=0, err=1.
  - err=0 for all legal modes.
- Storage: a main register (drives the outputs) plus a skid register.
- Accept: an entry is accepted when in_valid && in_ready. The input does not need to be held after acceptance.
- in_ready = !skid_valid, driven straight from a flop with no combinational path from out_ready.
- Transfer: occurs when out_valid && out_ready.
- Latency: an accepted entry appears on the outputs on the next edge when the main register is empty or transferring in the same cycle. Full throughput is 1 entry per cycle with out_ready held high.
- Buffer state, encoded by {main_valid, skid_valid}: EMPTY 00, ONE 10, FULL 11; 01 is unreachable.
  - EMPTY + accept -> ONE.
  - ONE + accept + transfer -> ONE, new data in main.
  - ONE + accept, no transfer -> FULL, new data in skid.
  - ONE + transfer, no accept -> EMPTY.
  - FULL + transfer -> ONE; skid moves to main and in_ready rises next cycle.
  - FULL: no accept is possible.
- Ordering: strict FIFO; there is never reordering between main and skid.
- Output stability: while out_valid=1 and out_ready=0, result, out_tag and err hold stable.
- Flush: clears both valids on the next edge and overrides any accept or transfer that cycle. An entry presented with flush is dropped. Data registers may keep stale values, but out_valid=0. in_ready=1 after the flush.
- Reset versus flush: reset has priority. Reset mid-stream discards all entries, with the same visible effect as flush plus output registers forced to 0.
- Width rules: all shifts are performed at OUT_W bits; overflow bits of SHL modes are discarded. IN_W >= OUT_W is a static assertion error.

Decomposition:
- ext_pkg holds:
  - localparams for the mode encodings (EXT_ZERO..EXT_SHL2Z) and the mode width of 3;
  - a function `is_legal_mode`.
- Sub-module ext_core is purely combinational (imm, mode -> value, err), parametrised on IN_W and OUT_W, and instanced once ahead of the skid buffer.
- ext_stage contains only the handshake and storage logic.

Test Plan:
1. Mode table, IN_W=16/OUT_W=32, out_ready=1. Input sequence and required result one cycle later with err=0:
   - SIGN 0x8001 -> 0xFFFF8001
   - ZERO 0x8001 -> 0x00008001
   - HIGH 0x1234 -> 0x12340000
   - ONES 0x00FF -> 0xFFFF00FF
   - SHL2 0xFFFF -> 0xFFFFFFFC
   - SHL2Z 0xFFFF -> 0x0003FFFC
2. Backpressure:
   - Hold out_ready=0 and offer A=0x0001, B=0x0002, C=0x0003 (SIGN, tags 1/2/3).
   - Required: A and B accepted, in_ready=0 the cycle after B, C held.
   - Then raise out_ready: outputs A, B, C in order with tags 1, 2, 3, and no loss or duplication.
3. Flush with entry: in FULL state, assert flush together with in_valid. Required: next cycle out_valid=0 and in_ready=1; no old or new entry is ever emitted.
4. Illegal mode: mode=7, imm=0xABCD -> result=0x00000000, err=1. A following SIGN entry shows err=0.
5. Reset mid-stream: with 2 entries buffered, pulse reset for 1 cycle. Required: out_valid=0, result=0, out_tag=0, in_ready=1; a new entry then passes with latency 1.
6. Throughput: 100 random back-to-back entries with out_ready=1. Required: 100 results in consecutive cycles, in_ready never deasserts, and values match the ext_core model.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and
// the legality test used by the extension core.
package ext_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] EXT_ZERO  = 3'd0;
  localparam logic [MODE_W-1:0] EXT_SIGN  = 3'd1;
  localparam logic [MODE_W-1:0] EXT_HIGH  = 3'd2;
  localparam logic [MODE_W-1:0] EXT_ONES  = 3'd3;
  localparam logic [MODE_W-1:0] EXT_SHL2  = 3'd4;
  localparam logic [MODE_W-1:0] EXT_SHL2Z = 3'd5;

  function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
    return (mode <= EXT_SHL2Z);
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational immediate widener: IN_W-bit immediate to OUT_W bits under
// one of six extension modes; modes 6 and 7 yield zero with err set.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  value,
  output logic              err
);

  if (IN_W < 1 || IN_W >= OUT_W) begin : g_width_check
    $error("ext_core: requires 1 <= IN_W < OUT_W");
  end

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = {{(OUT_W-IN_W){1'b0}}, imm};
  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    value = '0;
    err   = !is_legal_mode(mode);
    case (mode)
      EXT_ZERO:  value = zext;
      EXT_SIGN:  value = sext;
      EXT_HIGH:  value = {imm, {(OUT_W-IN_W){1'b0}}};
      EXT_ONES:  value = {{(OUT_W-IN_W){1'b1}}, imm};
      EXT_SHL2:  value = sext << 2;
      EXT_SHL2Z: value = zext << 2;
      default:   value = '0;
    endcase
  end

endmodule

// File: rtl/ext_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer so the
// downstream stall never reaches in_ready combinationally.
module ext_stage
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  input  logic [TAG_W-1:0]  tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              err
);

  // Buffer occupancy as {main_valid, skid_valid}; 01 cannot occur.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [OUT_W-1:0] core_value;
  logic             core_err;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm   (imm),
    .mode  (mode),
    .value (core_value),
    .err   (core_err)
  );

  logic             main_valid;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_result;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;
  logic             accept;
  logic             transfer;

  // skid_valid is a flop, so in_ready has no combinational dependence on out_ready.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid && in_ready;
  assign transfer  = main_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      result     <= '0;
      out_tag    <= '0;
      err        <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case ({main_valid, skid_valid})
        ST_EMPTY: begin
          if (accept) begin
            main_valid <= 1'b1;
            result     <= core_value;
            out_tag    <= tag;
            err        <= core_err;
          end
        end
        ST_ONE: begin
          if (accept && transfer) begin
            result  <= core_value;
            out_tag <= tag;
            err     <= core_err;
          end else if (accept) begin
            skid_valid <= 1'b1;
          end else if (transfer) begin
            main_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (transfer) begin
            skid_valid <= 1'b0;
            result     <= skid_result;
            out_tag    <= skid_tag;
            err        <= skid_err;
          end
        end
        default: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: skid payload has no reset; it is only ever observed behind skid_valid, which is reset.
  always_ff @(posedge clk) begin
    if (accept && main_valid && !transfer) begin
      skid_result <= core_value;
      skid_tag    <= tag;
      skid_err    <= core_err;
    end
  end

endmodule

// File: tb/tb_ext_stage.sv
// Self-checking bench for ext_stage: scoreboard of expected results filled on
// accept and drained on transfer, plus directed handshake/flush/reset checks.
module tb_ext_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] imm = '0;
  logic [2:0]  mode = '0;
  logic [4:0]  tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic        err;

  typedef struct packed {
    logic        e;
    logic [4:0]  t;
    logic [31:0] r;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   n_out = 0;

  always #5 clk = ~clk;

  ext_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .mode      (mode),
    .tag       (tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .err       (err)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] i, input logic [2:0] m, input logic [4:0] t);
    exp_t x;
    logic [31:0] s;
    s = i[15] ? (32'hFFFF_0000 | 32'(i)) : 32'(i);
    x.t = t;
    x.e = 1'b0;
    case (m)
      3'd0:    x.r = 32'(i);
      3'd1:    x.r = s;
      3'd2:    x.r = 32'(i) * 32'h0001_0000;
      3'd3:    x.r = 32'hFFFF_0000 | 32'(i);
      3'd4:    x.r = s * 32'd4;
      3'd5:    x.r = 32'(i) * 32'd4;
      default: begin x.r = 32'h0; x.e = 1'b1; end
    endcase
    return x;
  endfunction

  // Scoreboard: sample mid-cycle; the next rising edge commits what is seen here.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_output", 64'({err, out_tag, result}), 64'hDEAD);
        end else begin
          check("sb_result", 64'({err, out_tag, result}), 64'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(imm, mode, tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one entry and returns one step after the edge that accepts it.
  task automatic send(input logic [2:0] m, input logic [15:0] i, input logic [4:0] t,
                      output int waits);
    logic ok;
    in_valid = 1'b1;
    mode = m;
    imm = i;
    tag = t;
    waits = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) break;
      waits++;
      if (waits > 50) begin
        check("accept_timeout", 64'(waits), 64'd0);
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  typedef struct { logic [2:0] m; logic [15:0] i; logic [31:0] r; } row_t;
  row_t rows[6];

  initial begin
    int w;
    int base;
    exp_t ex;
    rows[0] = '{3'd1, 16'h8001, 32'hFFFF_8001};
    rows[1] = '{3'd0, 16'h8001, 32'h0000_8001};
    rows[2] = '{3'd2, 16'h1234, 32'h1234_0000};
    rows[3] = '{3'd3, 16'h00FF, 32'hFFFF_00FF};
    rows[4] = '{3'd4, 16'hFFFF, 32'hFFFF_FFFC};
    rows[5] = '{3'd5, 16'hFFFF, 32'h0003_FFFC};

    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Mode table at full rate, each result visible one edge after acceptance.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(rows[k].m, rows[k].i, 5'(k), w);
      check("mode_valid", 64'(out_valid), 64'd1);
      check("mode_result", 64'(result), 64'(rows[k].r));
      check("mode_err", 64'(err), 64'd0);
    end
    idle();
    repeat (3) step();

    // Backpressure: A and B fill the buffer, C waits until the consumer drains.
    out_ready = 1'b0;
    base = n_out;
    send(3'd1, 16'h0001, 5'd1, w);
    send(3'd1, 16'h0002, 5'd2, w);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    imm = 16'h0003;
    tag = 5'd3;
    repeat (3) begin
      step();
      check("bp_held_ready", 64'(in_ready), 64'd0);
      check("bp_stable_result", 64'(result), 64'h1);
      check("bp_stable_tag", 64'(out_tag), 64'd1);
    end
    out_ready = 1'b1;
    send(3'd1, 16'h0003, 5'd3, w);
    idle();
    repeat (4) step();
    check("bp_out_count", 64'(n_out - base), 64'd3);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush while full, with a new entry presented in the same cycle.
    out_ready = 1'b0;
    base = n_out;
    send(3'd0, 16'h1111, 5'd7, w);
    send(3'd0, 16'h2222, 5'd8, w);
    in_valid = 1'b1;
    imm = 16'h3333;
    tag = 5'd9;
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("flush_no_emit", 64'(out_valid), 64'd0);
    end
    check("flush_out_count", 64'(n_out - base), 64'd0);

    // Illegal mode, then a legal one clears err.
    send(3'd7, 16'hABCD, 5'd4, w);
    check("illegal_valid", 64'(out_valid), 64'd1);
    check("illegal_result", 64'(result), 64'd0);
    check("illegal_err", 64'(err), 64'd1);
    send(3'd1, 16'h1234, 5'd5, w);
    check("legal_err", 64'(err), 64'd0);
    check("legal_result", 64'(result), 64'h1234);
    idle();
    repeat (2) step();

    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(3'd1, 16'h7777, 5'd10, w);
    send(3'd1, 16'h8888, 5'd11, w);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_result", 64'(result), 64'd0);
    check("mrst_out_tag", 64'(out_tag), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(3'd4, 16'h0010, 5'd12, w);
    check("mrst_latency_valid", 64'(out_valid), 64'd1);
    check("mrst_latency_result", 64'(result), 64'h40);
    idle();
    repeat (2) step();

    // Throughput: 100 random entries back to back.
    base = n_out;
    for (int k = 0; k < 100; k++) begin
      send(3'($urandom_range(0, 7)), 16'($urandom), 5'($urandom), w);
      check("tput_wait", 64'(w), 64'd0);
      check("tput_valid", 64'(out_valid), 64'd1);
    end
    idle();
    repeat (3) step();
    check("tput_out_count", 64'(n_out - base), 64'd100);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    ex = model(16'hFFFF, 3'd4, 5'd0);
    check("model_sanity", 64'(ex.r), 64'hFFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
